param_fifo: RTL and testbench

Parametrised synchronous FIFO built on an internal register-file storage array with its own pointer and flag control. It replaces the fixed 8x32 storage plus external pointer logic in the UART TX/RX paths. It adds configurable width and depth, an occupancy count, and almost-full/almost-empty thresholds. It also adds sticky overflow/underflow error flags and a registered read port with a valid strobe.

---
 rtl/param_fifo_if.sv | 29 ++
 rtl/param_fifo.sv | 88 ++++++++
 tb/tb_param_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// Push/pop handshake bundle for param_fifo; master drives requests, slave is the FIFO.
interface param_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              iPush;
    logic [DATA_W-1:0] iPushData;
    logic              iPop;
    logic              iClrErr;
    logic [DATA_W-1:0] oPopData;
    logic              oPopValid;
    logic              oFull;
    logic              oEmpty;
    logic              oAFull;
    logic              oAEmpty;
    logic [ADDR_W:0]   oCount;
    logic              oOvf;
    logic              oUdf;

    modport master (
        output iPush, iPushData, iPop, iClrErr,
        input  oPopData, oPopValid, oFull, oEmpty, oAFull, oAEmpty, oCount, oOvf, oUdf
    );

    modport slave (
        input  iPush, iPushData, iPop, iClrErr,
        output oPopData, oPopValid, oFull, oEmpty, oAFull, oAEmpty, oCount, oOvf, oUdf
    );
endinterface

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: register-file storage, separate occupancy counter,
// threshold flags, sticky overflow/underflow and a registered read port.
module param_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned AFULL_TH  = 28,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic            iClk,
    input  logic            iRst_n,
    param_fifo_if.slave     bus
);
    localparam int unsigned DEPTH = 32'(1) << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic [CNT_W-1:0]  w_count_nxt;

    // Flags derive from the registered count only, so they change one cycle after the cause.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    // An empty FIFO never forwards same-cycle push data; a full one accepts a push only alongside a pop.
    assign w_pop_ok  = bus.iPop & ~w_empty;
    assign w_push_ok = bus.iPush & (~w_full | w_pop_ok);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge iClk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= bus.iPushData;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_pop_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr     <= r_rptr + ADDR_W'(1);
                r_pop_data <= r_mem[r_rptr];
            end
            // A new error in the clearing cycle wins over the clear.
            r_ovf <= (bus.iPush & ~w_push_ok) | (r_ovf & ~bus.iClrErr);
            r_udf <= (bus.iPop  & ~w_pop_ok)  | (r_udf & ~bus.iClrErr);
        end
    end

    assign bus.oPopData  = r_pop_data;
    assign bus.oPopValid = r_pop_valid;
    assign bus.oFull     = w_full;
    assign bus.oEmpty    = w_empty;
    assign bus.oAFull    = (r_count >= CNT_W'(AFULL_TH));
    assign bus.oAEmpty   = (r_count <= CNT_W'(AEMPTY_TH));
    assign bus.oCount    = r_count;
    assign bus.oOvf      = r_ovf;
    assign bus.oUdf      = r_udf;
endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo with default parameters (8 bits x 32 entries).
module tb_param_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    param_fifo_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    param_fifo #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(4)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.iPush = 1'b0; bus.iPushData = '0; bus.iPop = 1'b0; bus.iClrErr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        checks++; if (bus.oCount !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.oCount); end
        checks++; if (bus.oEmpty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.oEmpty); end
        checks++; if (bus.oAEmpty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", bus.oAEmpty); end
        checks++; if (bus.oFull !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.oFull); end
        checks++; if (bus.oAFull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", bus.oAFull); end
        checks++; if (bus.oPopValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.oPopValid); end
        checks++; if (bus.oPopData !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.oPopData); end
        checks++; if (bus.oOvf !== 1'b0 || bus.oUdf !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", bus.oOvf, bus.oUdf); end
        tick;
    endtask

    task automatic test_basic;
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            bus.iPush = 1'b1; bus.iPushData = vals[i];
            tick;
            checks++; if (bus.oPopValid !== 1'b0) begin failures++; $display("FAIL basic_push_valid got=%b exp=0", bus.oPopValid); end
        end
        bus.iPush = 1'b0;
        checks++; if (bus.oCount !== 6'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", bus.oCount); end
        checks++; if (bus.oAEmpty !== 1'b1 || bus.oEmpty !== 1'b0) begin failures++; $display("FAIL basic_flags got=%b%b exp=10", bus.oAEmpty, bus.oEmpty); end
        for (int i = 0; i < 3; i++) begin
            bus.iPop = 1'b1;
            tick;
            checks++; if (bus.oPopValid !== 1'b1) begin failures++; $display("FAIL basic_pop_valid got=%b exp=1", bus.oPopValid); end
            checks++; if (bus.oPopData !== vals[i]) begin failures++; $display("FAIL basic_pop_data got=%h exp=%h", bus.oPopData, vals[i]); end
            checks++; if (bus.oCount !== 6'(2 - i)) begin failures++; $display("FAIL basic_pop_count got=%0d exp=%0d", bus.oCount, 2 - i); end
        end
        bus.iPop = 1'b0;
        checks++; if (bus.oEmpty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", bus.oEmpty); end
        tick;
        checks++; if (bus.oPopValid !== 1'b0) begin failures++; $display("FAIL basic_idle_valid got=%b exp=0", bus.oPopValid); end
        checks++; if (bus.oPopData !== 8'h33) begin failures++; $display("FAIL basic_hold_data got=%h exp=33", bus.oPopData); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 32; i++) begin
            bus.iPush = 1'b1; bus.iPushData = 8'(i);
            tick;
            checks++; if (bus.oAFull !== ((i + 1) >= 28)) begin failures++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i + 1, bus.oAFull, ((i + 1) >= 28)); end
            checks++; if (bus.oFull !== ((i + 1) == 32)) begin failures++; $display("FAIL fill_full n=%0d got=%b exp=%b", i + 1, bus.oFull, ((i + 1) == 32)); end
        end
        bus.iPushData = 8'hAA;
        tick;
        bus.iPush = 1'b0;
        checks++; if (bus.oOvf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.oOvf); end
        checks++; if (bus.oCount !== 6'd32) begin failures++; $display("FAIL ovf_count got=%0d exp=32", bus.oCount); end
        for (int i = 0; i < 32; i++) begin
            bus.iPop = 1'b1;
            tick;
            checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, bus.oPopValid, bus.oPopData, 8'(i)); end
        end
        bus.iPop = 1'b0;
        checks++; if (bus.oCount !== 6'd0 || bus.oEmpty !== 1'b1) begin failures++; $display("FAIL drain_end got=%0d/%b exp=0/1", bus.oCount, bus.oEmpty); end
        checks++; if (bus.oOvf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.oOvf); end
        bus.iClrErr = 1'b1;
        tick;
        bus.iClrErr = 1'b0;
        checks++; if (bus.oOvf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus.oOvf); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3; i++) begin
            bus.iPush = 1'b1; bus.iPushData = 8'(8'h40 + i);
            tick;
        end
        for (int k = 0; k < 50; k++) begin
            bus.iPush = 1'b1; bus.iPushData = 8'(8'h43 + k); bus.iPop = 1'b1;
            tick;
            checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 8'(8'h40 + k)) begin failures++; $display("FAIL wrap_data k=%0d got=%b/%h exp=1/%h", k, bus.oPopValid, bus.oPopData, 8'(8'h40 + k)); end
            checks++; if (bus.oCount !== 6'd3) begin failures++; $display("FAIL wrap_count k=%0d got=%0d exp=3", k, bus.oCount); end
        end
        bus.iPush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.oPopData !== 8'(8'h72 + i)) begin failures++; $display("FAIL wrap_tail got=%h exp=%h", bus.oPopData, 8'(8'h72 + i)); end
        end
        bus.iPop = 1'b0;
        checks++; if (bus.oOvf !== 1'b0 || bus.oUdf !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b%b exp=00", bus.oOvf, bus.oUdf); end
        checks++; if (bus.oEmpty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", bus.oEmpty); end
    endtask

    task automatic test_full_simul;
        for (int i = 0; i < 32; i++) begin
            bus.iPush = 1'b1; bus.iPushData = 8'(8'h80 + i);
            tick;
        end
        checks++; if (bus.oFull !== 1'b1) begin failures++; $display("FAIL fs_full got=%b exp=1", bus.oFull); end
        bus.iPushData = 8'h5A; bus.iPop = 1'b1;
        tick;
        bus.iPush = 1'b0;
        checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 8'h80) begin failures++; $display("FAIL fs_pop got=%b/%h exp=1/80", bus.oPopValid, bus.oPopData); end
        checks++; if (bus.oCount !== 6'd32) begin failures++; $display("FAIL fs_count got=%0d exp=32", bus.oCount); end
        checks++; if (bus.oOvf !== 1'b0) begin failures++; $display("FAIL fs_ovf got=%b exp=0", bus.oOvf); end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] exp;
            exp = (i == 31) ? 8'h5A : 8'(8'h81 + i);
            tick;
            checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== exp) begin failures++; $display("FAIL fs_drain i=%0d got=%b/%h exp=1/%h", i, bus.oPopValid, bus.oPopData, exp); end
        end
        bus.iPop = 1'b0;
        checks++; if (bus.oEmpty !== 1'b1) begin failures++; $display("FAIL fs_empty got=%b exp=1", bus.oEmpty); end
    endtask

    task automatic test_empty_simul;
        bus.iPush = 1'b1; bus.iPushData = 8'h77; bus.iPop = 1'b1;
        tick;
        bus.iPush = 1'b0; bus.iPop = 1'b0;
        checks++; if (bus.oUdf !== 1'b1) begin failures++; $display("FAIL es_udf got=%b exp=1", bus.oUdf); end
        checks++; if (bus.oPopValid !== 1'b0) begin failures++; $display("FAIL es_valid got=%b exp=0", bus.oPopValid); end
        checks++; if (bus.oCount !== 6'd1) begin failures++; $display("FAIL es_count got=%0d exp=1", bus.oCount); end
        bus.iPop = 1'b1;
        tick;
        bus.iPop = 1'b0;
        checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 8'h77) begin failures++; $display("FAIL es_pop got=%b/%h exp=1/77", bus.oPopValid, bus.oPopData); end
        checks++; if (bus.oUdf !== 1'b1) begin failures++; $display("FAIL es_udf_sticky got=%b exp=1", bus.oUdf); end
        bus.iClrErr = 1'b1;
        tick;
        checks++; if (bus.oUdf !== 1'b0) begin failures++; $display("FAIL es_udf_clear got=%b exp=0", bus.oUdf); end
        bus.iPop = 1'b1;
        tick;
        bus.iPop = 1'b0;
        checks++; if (bus.oUdf !== 1'b1) begin failures++; $display("FAIL es_set_wins got=%b exp=1", bus.oUdf); end
        tick;
        bus.iClrErr = 1'b0;
        checks++; if (bus.oUdf !== 1'b0) begin failures++; $display("FAIL es_udf_clear2 got=%b exp=0", bus.oUdf); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 10; i++) begin
            bus.iPush = 1'b1; bus.iPushData = 8'(8'hC0 + i);
            tick;
        end
        bus.iPush = 1'b0; bus.iPop = 1'b1;
        tick;
        bus.iPop = 1'b0;
        checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 8'hC0 || bus.oCount !== 6'd9) begin failures++; $display("FAIL ar_pre got=%b/%h/%0d exp=1/c0/9", bus.oPopValid, bus.oPopData, bus.oCount); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.oCount !== 6'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", bus.oCount); end
        checks++; if (bus.oEmpty !== 1'b1) begin failures++; $display("FAIL ar_empty got=%b exp=1", bus.oEmpty); end
        checks++; if (bus.oPopValid !== 1'b0 || bus.oPopData !== 8'h00) begin failures++; $display("FAIL ar_pop got=%b/%h exp=0/00", bus.oPopValid, bus.oPopData); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.iPop = 1'b1;
        tick;
        bus.iPop = 1'b0;
        checks++; if (bus.oUdf !== 1'b1 || bus.oPopValid !== 1'b0) begin failures++; $display("FAIL ar_udf got=%b/%b exp=1/0", bus.oUdf, bus.oPopValid); end
        checks++; if (bus.oCount !== 6'd0) begin failures++; $display("FAIL ar_post_count got=%0d exp=0", bus.oCount); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_fill_overflow;
        test_wrap;
        test_full_simul;
        test_empty_simul;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
